// File: rtl/key_event_fifo.sv
// Converts debounced key levels into press and auto-repeat key-code events
// and queues them in a small first-word-fall-through FIFO.
module key_event_fifo #(
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold1,
    input  logic                   hold2,
    input  logic                   hold3,
    input  logic                   hold4,
    input  logic                   rd_en,
    output logic [1:0]             key_code,
    output logic                   key_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {PH_DELAY, PH_RATE} phase_t;

    logic [3:0]       hold;
    logic [3:0]       hold_q;
    logic [3:0]       press;
    logic [3:0]       rep;
    logic [3:0]       pending;
    logic [3:0]       pending_next;
    logic [3:0]       served;
    logic             single;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    phase_t           phase;
    phase_t           phase_next;
    logic [1:0]       sel;
    logic             full;
    logic             do_pop;
    logic             do_write;
    logic             do_drop;
    logic [1:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [1:0]       last_code;

    assign hold   = {hold4, hold3, hold2, hold1};
    assign press  = hold & ~hold_q;
    assign single = (hold != 4'b0) && ((hold & (hold - 4'd1)) == 4'b0);

    // Shared repeat timer: only runs while exactly one key is held unchanged
    always_comb begin
        cnt_next   = cnt + CNT_W'(1);
        phase_next = phase;
        rep        = 4'b0;
        if ((hold != hold_q) || !single) begin
            cnt_next   = '0;
            phase_next = PH_DELAY;
        end else if ((phase == PH_DELAY) && (cnt == CNT_W'(REPEAT_DELAY - 1))) begin
            rep        = hold;
            cnt_next   = '0;
            phase_next = PH_RATE;
        end else if ((phase == PH_RATE) && (cnt == CNT_W'(REPEAT_RATE - 1))) begin
            rep        = hold;
            cnt_next   = '0;
        end
    end

    // Fixed priority: the lowest-numbered pending key is served each cycle
    always_comb begin
        sel    = 2'd0;
        served = 4'b0;
        for (int k = 3; k >= 0; k--) begin
            if (pending[k]) sel = 2'(k);
        end
        if (pending != 4'b0) served[sel] = 1'b1;
    end

    assign pending_next = (pending & ~served) | press | rep;
    assign key_valid    = (count != '0);
    assign full         = (count == (AW+1)'(DEPTH));
    assign do_pop       = rd_en & key_valid;
    assign do_write     = (pending != 4'b0) && (!full || do_pop);
    assign do_drop      = (pending != 4'b0) && full && !do_pop;
    assign key_code     = key_valid ? mem[rd_ptr] : last_code;

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= sel;
    end

    // last_code keeps the most recently popped head visible while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 4'b0;
            pending   <= 4'b0;
            cnt       <= '0;
            phase     <= PH_DELAY;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            last_code <= 2'd0;
        end else begin
            hold_q   <= hold;
            pending  <= pending_next;
            cnt      <= cnt_next;
            phase    <= phase_next;
            overflow <= do_drop;
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_code <= mem[rd_ptr];
            end
            if (do_write && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_write && do_pop)
                count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: fixed vector table, directed corner sequences and
// random key activity compared against a queue-based reference model.
module tb_key_event_fifo;

    localparam int DEPTH = 4;
    localparam int RDLY  = 10;
    localparam int RRATE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hold;
    logic       rd_en;
    logic [1:0] key_code;
    logic       key_valid;
    logic [2:0] count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] hold;
        logic       rd;
        logic       exp_valid;
        logic [1:0] exp_code;
        logic [2:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[13];

    // Reference model state
    int         m_q[$];
    logic [3:0] m_pend;
    logic [3:0] m_prev;
    int         m_last;
    bit         m_ovf;
    int         m_edge;
    int         m_run_start;

    key_event_fifo #(
        .DEPTH(DEPTH), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hold1(hold[0]), .hold2(hold[1]), .hold3(hold[2]), .hold4(hold[3]),
        .rd_en(rd_en), .key_code(key_code), .key_valid(key_valid),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend      = 4'b0;
        m_prev      = 4'b0;
        m_last      = 0;
        m_ovf       = 1'b0;
        m_run_start = m_edge;
    endtask

    // Repeats fall at DELAY, DELAY+RATE, ... edges after the last disturbance
    task automatic model_edge(input logic [3:0] h, input logic r);
        logic [3:0] served;
        logic [3:0] rep;
        bit         pop;
        bit         wr;
        int         s;
        int         d;
        rep = 4'b0;
        if ((h != m_prev) || ($countones(h) != 1)) begin
            m_run_start = m_edge;
        end else begin
            d = m_edge - m_run_start;
            if ((d >= RDLY) && (((d - RDLY) % RRATE) == 0)) rep = h;
        end
        pop    = r && (m_q.size() > 0);
        served = 4'b0;
        wr     = 1'b0;
        m_ovf  = 1'b0;
        s      = 0;
        if (m_pend != 4'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_pend[k] && served == 4'b0) begin
                    s = k;
                    served[k] = 1'b1;
                end
            end
            if ((m_q.size() < DEPTH) || pop) wr = 1'b1;
            else m_ovf = 1'b1;
        end
        if (pop) m_last = m_q.pop_front();
        if (wr) m_q.push_back(s);
        m_pend = (m_pend & ~served) | (h & ~m_prev) | rep;
        m_prev = h;
        m_edge++;
    endtask

    task automatic apply_stimulus(input logic [3:0] h, input logic r);
        hold  = h;
        rd_en = r;
        model_edge(h, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag);
        int exp_code;
        exp_code = (m_q.size() > 0) ? m_q[0] : m_last;
        check_val({tag, " key_valid"}, key_valid, (m_q.size() > 0));
        check_val({tag, " key_code"}, key_code, exp_code);
        check_val({tag, " count"}, count, m_q.size());
        check_val({tag, " overflow"}, overflow, m_ovf);
    endtask

    task automatic step(input string tag, input logic [3:0] h, input logic r);
        apply_stimulus(h, r);
        check_output(tag);
    endtask

    initial begin
        vecs[0]  = '{4'b1001, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[1]  = '{4'b1001, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0};
        vecs[2]  = '{4'b1001, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0};
        vecs[3]  = '{4'b1001, 1'b1, 1'b1, 2'd3, 3'd1, 1'b0};
        vecs[4]  = '{4'b1001, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0};
        vecs[10] = '{4'b0100, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0};
        vecs[11] = '{4'b0100, 1'b1, 1'b1, 2'd2, 3'd1, 1'b0};
        vecs[12] = '{4'b0100, 1'b1, 1'b0, 2'd2, 3'd0, 1'b0};

        m_edge = 0;
        hold   = 4'b0;
        rd_en  = 1'b0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("reset key_valid", key_valid, 0);
        check_val("reset count", count, 0);
        check_val("reset overflow", overflow, 0);
        check_val("reset key_code", key_code, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step("idle", 4'b0000, 1'b0);

        // Simultaneous press, pops, empty reads and write-with-read when empty
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].hold, vecs[i].rd);
            check_val($sformatf("vec%0d key_valid", i), key_valid, vecs[i].exp_valid);
            check_val($sformatf("vec%0d key_code", i), key_code, vecs[i].exp_code);
            check_val($sformatf("vec%0d count", i), count, vecs[i].exp_count);
            check_val($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_ovf);
        end

        // Single press with auto-repeat filling the FIFO
        repeat (2) step("release", 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("single", 4'b0100, 1'b0);
            if (i == 1) begin
                check_val("single first count", count, 1);
                check_val("single first code", key_code, 2);
            end
            if (i == 10) check_val("single before rep", count, 1);
            if (i == 11) check_val("single rep1", count, 2);
        end
        check_val("single full count", count, 4);

        // Overflow drop, then the same press accepted with a pop on the write edge
        step("ovf press", 4'b0001, 1'b0);
        step("ovf drop", 4'b0001, 1'b0);
        check_val("ovf pulse", overflow, 1);
        check_val("ovf count", count, 4);
        step("ovf after", 4'b0001, 1'b0);
        check_val("ovf one cycle", overflow, 0);
        step("ovf release", 4'b0000, 1'b0);
        step("ovf press2", 4'b0001, 1'b0);
        step("ovf popwrite", 4'b0001, 1'b1);
        check_val("popwrite count", count, 4);
        check_val("popwrite overflow", overflow, 0);
        check_val("popwrite head", key_code, 2);

        // Repeat restart when a second key joins and leaves
        repeat (6) step("drain", 4'b0000, 1'b1);
        repeat (12) step("hold2", 4'b0010, 1'b1);
        repeat (3) step("hold12", 4'b0011, 1'b1);
        for (int j = 0; j < 14; j++) begin
            step("restart", 4'b0010, 1'b1);
            if (j == 10) check_val("restart quiet", key_valid, 0);
            if (j == 11) begin
                check_val("restart rep valid", key_valid, 1);
                check_val("restart rep code", key_code, 1);
            end
        end

        // Asynchronous reset with queued and pending events
        repeat (6) step("drain2", 4'b0000, 1'b1);
        step("fill", 4'b0001, 1'b0);
        step("fill", 4'b0000, 1'b0);
        step("fill", 4'b0010, 1'b0);
        step("fill", 4'b0000, 1'b0);
        step("fill", 4'b0100, 1'b0);
        step("fill", 4'b0110, 1'b0);
        check_val("prereset count", count, 3);
        hold = 4'b0010;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("midreset key_valid", key_valid, 0);
        check_val("midreset count", count, 0);
        check_val("midreset overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        step("postreset1", 4'b0010, 1'b0);
        check_val("postreset1 valid", key_valid, 0);
        step("postreset2", 4'b0010, 1'b0);
        check_val("postreset2 valid", key_valid, 1);
        check_val("postreset2 code", key_code, 1);

        // Random key activity with slowly changing levels
        begin
            logic [3:0] h;
            h = 4'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 3))
                        0, 1: h = 4'b0001 << $urandom_range(0, 3);
                        2:    h = 4'b0000;
                        default: h = 4'($urandom_range(0, 15));
                    endcase
                end
                step("random", h, ($urandom_range(0, 2) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
Sits directly downstream of the 4-key debouncer and consumes its debounced hold1..hold4 levels. It turns each press into a 2-bit key-code event and adds auto-repeat while exactly one key stays held. Events are buffered in a small first-word-fall-through FIFO, so game logic can pop key presses at its own pace without missing any.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >= 2
REPEAT_DELAY, 25000000, cycles from press event to first repeat event (0.5 s at 50 MHz); >= 2
REPEAT_RATE, 5000000, cycles between subsequent repeat events; >= 2
CNT_W, 25, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)-1

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
hold1..hold4  in  1 each  debounced key levels from the debouncer (key index 0..3)
rd_en  in  1  pop request; acts only when key_valid=1
key_code  out  2  key index at FIFO head; valid while key_valid=1
key_valid  out  1  FIFO not empty
count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset (async, rst_n=0): FIFO empty; pointers, pending[3:0], hold_q[3:0], repeat counter and phase all 0; outputs key_code=0, key_valid=0, count=0, overflow=0. Reset mid-operation discards all queued and pending events. A key still held at reset release produces a press event, because hold_q restarts at 0.
- Edge detect: hold_q <= {hold4..hold1} every cycle. press[k] = hold[k] & ~hold_q[k].
- Repeat counter (single, shared):
  - Clear cnt to 0 and set phase to DELAY on any cycle where hold != hold_q, or popcount(hold) != 1.
  - Otherwise, if phase=DELAY and cnt==REPEAT_DELAY-1: rep event for the held key, cnt<=0, phase<=RATE.
  - Otherwise, if phase=RATE and cnt==REPEAT_RATE-1: rep event, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - Timing: press event at edge N gives rep events at edges N+REPEAT_DELAY, then +REPEAT_RATE each.
- Pending: pending[k] <= (pending[k] & ~served[k]) | press[k] | rep[k].
  - An event arriving while the same key is already pending merges; no duplicate is queued.
  - A new event for key k on the same edge that serves k re-sets pending[k].
- Arbiter: each cycle, if pending != 0, select the lowest set index s; served[s]=1 at that edge.
  - If FIFO not full, or full with a pop on the same edge: write code s.
  - If full and no pop: drop the event, clear pending[s], overflow=1 for that cycle.
  - At most one write per cycle.
- Latency: hold[k] rises before edge N; pending set at edge N; FIFO write at edge N+1; key_valid=1 and key_code=k after edge N+1, provided no lower-index key is pending.
- FIFO:
  - First-word-fall-through; key_code is driven from the head entry combinationally from the registered read pointer.
  - Pop happens at posedge when rd_en & key_valid. rd_en while empty is ignored, with no underflow and pointers unchanged.
  - Simultaneous write and pop: count unchanged. This is allowed when full (write accepted, overflow stays 0).
  - When empty with rd_en and a write on the same edge: write only; count becomes 1.
  - Pointers are $clog2(DEPTH) bits and wrap naturally. count is a register, +1 on write-only, -1 on pop-only.
  - key_code is held at its last head value when empty; it is 0 after reset.
- overflow is registered: it is high for exactly the cycle after the dropping edge, once per dropped event.

Test Plan:
Bench parameters: DEPTH=4, REPEAT_DELAY=10, REPEAT_RATE=4.
1. Single press: hold3 0->1 before edge N, no rd_en -> key_valid=1, key_code=2, count=1 after edge N+1; with hold3 kept high, rep writes at edges N+11, N+15, N+19 (count reaches 4 after N+19).
2. Simultaneous press: hold1 and hold4 rise together before edge N -> writes code 0 at N+1 and code 3 at N+2; no repeat (two keys held); popping twice yields 0 then 3, then key_valid=0.
3. Overflow: fill to 4 with no reads, then one more press -> overflow pulses exactly 1 cycle, count stays 4, FIFO contents unchanged. Repeat the press with rd_en=1 on the write edge -> write accepted, count stays 4, no overflow.
4. Repeat restart: hold2 held for 12 cycles, then hold1 added -> press event for code 0, counter restarts; release hold1 -> next rep for code 1 occurs 10 cycles after the release edge.
5. Empty corner: rd_en=1 while empty for 5 cycles -> count stays 0, no pointer change. rd_en high on the same edge as the first write -> count=1 afterwards.
6. Reset mid-operation: count=3 and pending non-zero, assert rst_n=0 asynchronously mid-cycle -> key_valid, count and overflow are 0 immediately. With hold2 still high at release -> code 1 appears 2 edges after release.
